// File: rtl/tile_renderer.sv
// tile_renderer: pipelined tile/palette pixel generator with host writes, wrap scrolling and post-reset clear
module tile_renderer #(
  parameter int COLS = 40,
  parameter int ROWS = 30,
  parameter int NUM_TILES = 64,
  parameter int PAL_ENTRIES = 16,
  parameter int CB = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] pix_x,
  input  logic [11:0] pix_y,
  input  logic        pix_de,
  input  logic [11:0] scroll_x,
  input  logic [11:0] scroll_y,
  input  logic        wr_en,
  input  logic [1:0]  wr_sel,
  input  logic [11:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        busy,
  output logic        out_de,
  output logic [7:0]  out_r,
  output logic [7:0]  out_g,
  output logic [7:0]  out_b
);
  localparam int W = COLS * 8;
  localparam int H = ROWS * 8;
  localparam int MAP = COLS * ROWS;
  localparam int TDEP = NUM_TILES * 8;
  localparam int BIG = MAP > TDEP ? MAP : TDEP;
  localparam int CLR = BIG > PAL_ENTRIES ? BIG : PAL_ENTRIES;
  localparam int CW = $clog2(CLR + 1);
  localparam int WA = CW > 12 ? CW : 12;
  localparam int MA = $clog2(MAP);
  localparam int TA = $clog2(TDEP);
  localparam int TW = TA - 3;
  localparam int PA = $clog2(PAL_ENTRIES);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_n;
  logic [CW-1:0] clr_addr;
  logic [3*CB-1:0] paldef [PAL_ENTRIES];
  logic [7:0] tiledef [TDEP];
  logic [7:0] attrmap [MAP];
  logic [TW-1:0] tilemap [MAP];
  logic [WA-1:0] wa;
  logic [15:0] wd;
  logic hw, we_pal, we_tile, we_attr, we_map;
  logic [12:0] ax, ay;
  logic [11:0] sx0, sy0;
  logic de0, de1, de2, oob0, oob1, oob2, kill;
  logic [MA-1:0] m;
  logic [TW-1:0] t1;
  logic [7:0] a1, a2, row2;
  logic [2:0] sx1, sy1, sx2;
  logic [3:0] idx;
  logic [3*CB-1:0] pal;
  always_ff @(posedge clk) begin
    state <= reset ? CLEAR : state_n;
    clr_addr <= reset ? '0 : clr_addr + CW'(busy);
  end
  always_comb state_n = (state == CLEAR && clr_addr == CW'(CLR - 1)) ? RUN : state;
  assign busy = state == CLEAR;
  // the clear sweep borrows the host write port, so one address mux serves both
  assign wa = busy ? WA'(clr_addr) : WA'(wr_addr);
  assign wd = busy ? '0 : wr_data;
  assign hw = !busy && wr_en;
  assign we_pal = (busy || (hw && wr_sel == 2'd0)) && wa < WA'(PAL_ENTRIES);
  assign we_tile = (busy || (hw && wr_sel == 2'd1)) && wa < WA'(TDEP);
  assign we_attr = (busy || (hw && wr_sel == 2'd2)) && wa < WA'(MAP);
  assign we_map = (busy || (hw && wr_sel == 2'd3)) && wa < WA'(MAP);
  always_ff @(posedge clk) begin
    if (we_pal) paldef[PA'(wa)] <= (3*CB)'(wd);
    if (we_tile) tiledef[TA'(wa)] <= 8'(wd);
    if (we_attr) attrmap[MA'(wa)] <= 8'(wd);
    if (we_map) tilemap[MA'(wa)] <= TW'(wd);
  end
  assign ax = {1'b0, pix_x} + {1'b0, scroll_x};
  assign ay = {1'b0, pix_y} + {1'b0, scroll_y};
  assign m = MA'(int'(sy0 >> 3) * COLS + int'(sx0 >> 3));
  assign idx = row2[3'd7 - sx2] ? a2[7:4] : a2[3:0];
  assign pal = int'(idx) < PAL_ENTRIES ? paldef[PA'(idx)] : '0;
  assign kill = !de2 || oob2 || busy;
  always_ff @(posedge clk) begin
    if (reset) begin
      {de0, de1, de2, out_de} <= '0;
      {out_r, out_g, out_b} <= '0;
    end else begin
      {de0, de1, de2, out_de} <= {pix_de, de0, de1, de2};
      out_r <= kill ? '0 : 8'(pal[3*CB-1 -: CB]) << (8 - CB);
      out_g <= kill ? '0 : 8'(pal[2*CB-1 -: CB]) << (8 - CB);
      out_b <= kill ? '0 : 8'(pal[CB-1 -: CB]) << (8 - CB);
    end
  end
  always_ff @(posedge clk) begin
    sx0 <= ax >= 13'(W) ? 12'(ax - 13'(W)) : ax[11:0];
    sy0 <= ay >= 13'(H) ? 12'(ay - 13'(H)) : ay[11:0];
    oob0 <= pix_x >= 12'(W) || pix_y >= 12'(H);
    t1 <= tilemap[m];
    a1 <= attrmap[m];
    sx1 <= sx0[2:0];
    sy1 <= sy0[2:0];
    oob1 <= oob0;
    row2 <= tiledef[{t1, sy1}];
    a2 <= a1;
    sx2 <= sx1;
    oob2 <= oob1;
  end
endmodule

// File: tb/tb_tile_renderer.sv
// tb_tile_renderer: randomized and directed checks of tile_renderer against a pixel-level reference model
module tb_tile_renderer;
  localparam int W = 320, H = 240, MAP = 1200, TD = 512, NP = 16;
  logic clk = 0, reset = 1;
  logic [11:0] pix_x = 0, pix_y = 0, scroll_x = 0, scroll_y = 0, wr_addr = 0;
  logic pix_de = 0, wr_en = 0;
  logic [1:0] wr_sel = 0;
  logic [15:0] wr_data = 0;
  logic busy, out_de;
  logic [7:0] out_r, out_g, out_b;
  int compared = 0, mismatched = 0;
  bit chk_on = 0, bp;
  int pal_m [NP], tile_m [TD], attr_m [MAP], map_m [MAP];
  int clr_cnt = MAP;
  logic q_de [4] = '{0, 0, 0, 0};
  int q_rgb [4] = '{0, 0, 0, 0};
  logic q_care [4] = '{1, 1, 1, 1};
  tile_renderer dut (
    .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y), .pix_de(pix_de),
    .scroll_x(scroll_x), .scroll_y(scroll_y), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .out_de(out_de),
    .out_r(out_r), .out_g(out_g), .out_b(out_b)
  );
  always #5 clk = ~clk;
  function automatic int color(int x, int y, int scx, int scy);
    int sx, sy, row, b, idx, p;
    if (x >= W || y >= H) return 0;
    sx = (x + scx) % W;
    sy = (y + scy) % H;
    row = tile_m[map_m[(sy / 8) * 40 + sx / 8] * 8 + sy % 8];
    b = (row >> (7 - sx % 8)) & 1;
    idx = b ? attr_m[(sy / 8) * 40 + sx / 8] >> 4 : attr_m[(sy / 8) * 40 + sx / 8] & 15;
    p = idx < NP ? pal_m[idx] : 0;
    return (((p >> 8) & 15) << 20) | (((p >> 4) & 15) << 12) | ((p & 15) << 4);
  endfunction
  always @(posedge clk) begin
    bp = clr_cnt != 0;
    if (reset) begin
      foreach (pal_m[i]) pal_m[i] = 0;
      foreach (tile_m[i]) tile_m[i] = 0;
      foreach (attr_m[i]) attr_m[i] = 0;
      foreach (map_m[i]) map_m[i] = 0;
      clr_cnt = MAP;
      for (int i = 0; i < 4; i++) begin
        q_de[i] = 0;
        q_rgb[i] = 0;
        q_care[i] = 1;
      end
    end else begin
      if (!bp && wr_en) begin
        if (wr_sel == 0 && wr_addr < NP) pal_m[wr_addr] = wr_data & 'hfff;
        if (wr_sel == 1 && wr_addr < TD) tile_m[wr_addr] = wr_data & 'hff;
        if (wr_sel == 2 && wr_addr < MAP) attr_m[wr_addr] = wr_data & 'hff;
        if (wr_sel == 3 && wr_addr < MAP) map_m[wr_addr] = wr_data & 63;
      end
      q_de[3] = q_de[2];
      q_rgb[3] = bp ? 0 : q_rgb[2];
      q_care[3] = bp ? 1'b1 : q_care[2];
      for (int i = 2; i > 0; i--) begin
        q_de[i] = q_de[i-1];
        q_rgb[i] = q_rgb[i-1];
        q_care[i] = q_care[i-1];
      end
      q_de[0] = pix_de;
      q_rgb[0] = pix_de ? color(pix_x, pix_y, scroll_x, scroll_y) : 0;
      q_care[0] = !bp || !pix_de;
      if (clr_cnt > 0) clr_cnt--;
    end
  end
  always @(negedge clk) if (chk_on) begin
    compared++;
    if (out_de !== q_de[3]) begin
      mismatched++;
      $display("FAIL out_de t=%0t got %b expected %b", $time, out_de, q_de[3]);
    end
    compared++;
    if (busy !== (clr_cnt != 0)) begin
      mismatched++;
      $display("FAIL busy t=%0t got %b expected %b", $time, busy, clr_cnt != 0);
    end
    if (q_care[3]) begin
      compared++;
      if ({out_r, out_g, out_b} !== 24'(q_rgb[3])) begin
        mismatched++;
        $display("FAIL rgb t=%0t got %h expected %h", $time, {out_r, out_g, out_b}, 24'(q_rgb[3]));
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic wr(input int sel, input int addr, input int data);
    wr_en = 1;
    wr_sel = 2'(sel);
    wr_addr = 12'(addr);
    wr_data = 16'(data);
    tick();
    wr_en = 0;
  endtask
  task automatic pxc(input string name, input int x, input int y, input int scx, input int scy,
                     input logic de, input logic exp_de, input int exp_rgb);
    pix_x = 12'(x);
    pix_y = 12'(y);
    scroll_x = 12'(scx);
    scroll_y = 12'(scy);
    pix_de = de;
    tick();
    pix_de = 0;
    repeat (3) tick();
    chk({name, "_de"}, 32'(out_de), 32'(exp_de));
    chk({name, "_rgb"}, {8'h0, out_r, out_g, out_b}, exp_rgb);
  endtask
  initial begin
    int n, sel, addr;
    tick();
    chk_on = 1;
    tick();
    chk("reset_busy", 32'(busy), 1);
    chk("reset_de", 32'(out_de), 0);
    chk("reset_rgb", {8'h0, out_r, out_g, out_b}, 0);
    reset = 0;
    wr_en = 1;
    wr_sel = 0;
    wr_addr = 1;
    wr_data = 16'h0abc;
    n = 0;
    while (busy && n < 1300) begin
      tick();
      n++;
    end
    wr_en = 0;
    chk("busy_cycles", n, 1200);
    wr(2, 0, 'h11);
    pxc("pal1_untouched", 0, 0, 0, 0, 1, 1, 0);
    wr(0, 2, 'hf80);
    wr(0, 5, 'h0f0);
    wr(3, 0, 3);
    wr(2, 0, 'h52);
    wr(1, 24, 'h80);
    pxc("px00", 0, 0, 0, 0, 1, 1, 'h00f000);
    pxc("px10", 1, 0, 0, 0, 1, 1, 'hf08000);
    pxc("scroll_x_wrap", 1, 0, 319, 0, 1, 1, 'h00f000);
    pxc("scroll_y_wrap", 0, 1, 0, 239, 1, 1, 'h00f000);
    pxc("scroll_y_bg", 1, 1, 0, 239, 1, 1, 'hf08000);
    pxc("oob_x", 320, 0, 0, 0, 1, 1, 0);
    pxc("de_low", 0, 0, 0, 0, 0, 0, 0);
    wr(3, 0, 0);
    pix_x = 0;
    pix_y = 0;
    scroll_x = 0;
    scroll_y = 0;
    pix_de = 1;
    tick();
    pix_de = 0;
    wr_en = 1;
    wr_sel = 3;
    wr_addr = 0;
    wr_data = 3;
    tick();
    wr_en = 0;
    repeat (2) tick();
    chk("read_first_rgb", {8'h0, out_r, out_g, out_b}, 'hf08000);
    pxc("after_write", 0, 0, 0, 0, 1, 1, 'h00f000);
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 60; i++) begin
        sel = $urandom_range(0, 3);
        addr = sel == 0 ? $urandom_range(0, 19) : sel == 1 ? $urandom_range(0, 530) : $urandom_range(0, 1220);
        wr(sel, addr, $urandom_range(0, 65535));
      end
      repeat (4) tick();
      for (int i = 0; i < 150; i++) begin
        pix_x = 12'($urandom_range(0, 339));
        pix_y = 12'($urandom_range(0, 249));
        scroll_x = 12'($urandom_range(0, 319));
        scroll_y = 12'($urandom_range(0, 239));
        pix_de = $urandom_range(0, 3) != 0;
        tick();
      end
      pix_de = 0;
      repeat (4) tick();
    end
    for (int i = 0; i < 10; i++) begin
      pix_x = 12'($urandom_range(0, 319));
      pix_y = 12'($urandom_range(0, 239));
      pix_de = 1;
      reset = i == 4;
      tick();
      reset = 0;
      if (i >= 4 && i < 8) chk($sformatf("reset_flush_de%0d", i), 32'(out_de), 0);
      if (i >= 4) chk($sformatf("reset_busy%0d", i), 32'(busy), 1);
      if (i == 8) chk("post_reset_de", 32'(out_de), 1);
      if (i == 8) chk("post_reset_rgb", {8'h0, out_r, out_g, out_b}, 0);
    end
    pix_de = 0;
    n = 0;
    while (busy && n < 1300) begin
      tick();
      n++;
    end
    chk("busy_drop_after_reset", 32'(busy), 0);
    wr(0, 0, 'h123);
    for (int i = 0; i < 40; i++) begin
      pix_x = 12'($urandom_range(0, 319));
      pix_y = 12'($urandom_range(0, 239));
      pix_de = 1;
      tick();
    end
    pix_de = 0;
    repeat (3) tick();
    chk("cleared_bg_rgb", {8'h0, out_r, out_g, out_b}, 'h102030);
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
